// File: rtl/imm_encoder_pkg.sv
// Shared encodings for the RV32I immediate encoder. The ExtOp values match the
// decode-side immediate generator so the two can be driven from the same field.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_U = 3'b001,
    EXT_S = 3'b010,
    EXT_B = 3'b011,
    EXT_J = 3'b100,
    EXT_R = 3'b101
  } extOp_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_OP    = 2'b11
  } err_t;

  localparam int INSTR_W = 32;

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check of an immediate against its instruction format.
// Priority is illegal ExtOp, then range, then misalignment.
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic        [2:0]  extOp,
  input  logic signed [31:0] imm,
  output err_t               err
);

  logic fits12;
  logic fits13;
  logic fits21;
  logic lowZero;

  // A value fits an N-bit signed field when every bit above the field's sign bit copies it.
  assign fits12  = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13  = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21  = (&imm[31:20]) | ~(|imm[31:20]);
  assign lowZero = ~(|imm[11:0]);

  always_comb begin
    err = ERR_OK;
    case (extOp)
      EXT_I, EXT_S: if (!fits12) err = ERR_RANGE;
      EXT_U:        if (!lowZero) err = ERR_RANGE;
      EXT_B: begin
        if (!fits13)     err = ERR_RANGE;
        else if (imm[0]) err = ERR_ALIGN;
      end
      EXT_J: begin
        if (!fits21)     err = ERR_RANGE;
        else if (imm[0]) err = ERR_ALIGN;
      end
      EXT_R:   err = ERR_OK;
      default: err = ERR_OP;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction packer: stage 1 registers fields and the range
// verdict, stage 2 assembles the word; saturating counters track delivered words.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         ExtOp,
  input  logic [31:0]        imm,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic [1:0]         err,
  output logic [CNT_W-1:0]   cnt_ok,
  output logic [CNT_W-1:0]   cnt_err
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic adv1;
  logic adv2;

  logic                     vld_p1;
  logic        [2:0]        extOp_p1;
  logic signed [31:0]       imm_p1;
  logic        [6:0]        opcode_p1;
  logic        [4:0]        rd_p1;
  logic        [4:0]        rs1_p1;
  logic        [4:0]        rs2_p1;
  logic        [2:0]        funct3_p1;
  logic        [6:0]        funct7_p1;
  err_t                     err_p1;

  logic                     vld_p2;
  logic [INSTR_W-1:0]       instr_p2;
  err_t                     err_p2;
  logic [CNT_W-1:0]         cntOk;
  logic [CNT_W-1:0]         cntErr;

  err_t                     rangeErr;
  logic [INSTR_W-1:0]       packed_p1;

  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  imm_range_check uRangeCheck (
    .extOp (ExtOp),
    .imm   (imm),
    .err   (rangeErr)
  );

  // ---- stage 1: capture fields and legality verdict ----
  always_ff @(posedge clk) begin
    if (rst)       vld_p1 <= 1'b0;
    else if (adv1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      extOp_p1  <= ExtOp;
      imm_p1    <= imm;
      opcode_p1 <= opcode;
      rd_p1     <= rd;
      rs1_p1    <= rs1;
      rs2_p1    <= rs2;
      funct3_p1 <= funct3;
      funct7_p1 <= funct7;
      err_p1    <= rangeErr;
    end
  end

  // Packing uses the truncated immediate even when err flags it, so a bad
  // request still shows which bits would have landed in the word.
  always_comb begin
    packed_p1 = '0;
    case (extOp_p1)
      EXT_I: packed_p1 = {imm_p1[11:0], rs1_p1, funct3_p1, rd_p1, opcode_p1};
      EXT_U: packed_p1 = {imm_p1[31:12], rd_p1, opcode_p1};
      EXT_S: packed_p1 = {imm_p1[11:5], rs2_p1, rs1_p1, funct3_p1, imm_p1[4:0], opcode_p1};
      EXT_B: packed_p1 = {imm_p1[12], imm_p1[10:5], rs2_p1, rs1_p1, funct3_p1,
                          imm_p1[4:1], imm_p1[11], opcode_p1};
      EXT_J: packed_p1 = {imm_p1[20], imm_p1[10:1], imm_p1[11], imm_p1[19:12], rd_p1, opcode_p1};
      EXT_R: packed_p1 = {funct7_p1, rs2_p1, rs1_p1, funct3_p1, rd_p1, opcode_p1};
      default: packed_p1 = '0;
    endcase
  end

  // ---- stage 2: output register and statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      instr_p2 <= '0;
      err_p2   <= ERR_OK;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        instr_p2 <= packed_p1;
        err_p2   <= err_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cntOk  <= '0;
      cntErr <= '0;
    end else if (vld_p2 && out_ready) begin
      if (err_p2 == ERR_OK) cntOk  <= satInc(cntOk);
      else                  cntErr <= satInc(cntErr);
    end
  end

  assign out_valid = vld_p2;
  assign instr     = instr_p2;
  assign err       = err_p2;
  assign cnt_ok    = cntOk;
  assign cnt_err   = cntErr;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed format cases, backpressure, reset, then a
// randomized stream scored against an arithmetic model and a reference decoder.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [2:0]  rExt;
  logic [31:0] rImm;
  logic [6:0]  rOp;
  logic [4:0]  rRd;
  logic [4:0]  rRs1;
  logic [4:0]  rRs2;
  logic [2:0]  rF3;
  logic [6:0]  rF7;
  logic        outValid;
  logic        outReady;
  logic [31:0] instr;
  logic [1:0]  err;
  logic [15:0] cntOk;
  logic [15:0] cntErr;

  logic        inReady4;
  logic        outValid4;
  logic [31:0] instr4;
  logic [1:0]  err4;
  logic [3:0]  cntOk4;
  logic [3:0]  cntErr4;

  int nAsserts = 0;
  int nFails   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
    logic [2:0]  ext;
    logic [31:0] imm;
  } exp_t;

  exp_t q[$];
  int   okCount;
  int   errCount;
  int   delivered;
  bit   sawStall;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .ExtOp(rExt), .imm(rImm), .opcode(rOp), .rd(rRd), .rs1(rRs1), .rs2(rRs2),
    .funct3(rF3), .funct7(rF7), .out_valid(outValid), .out_ready(outReady),
    .instr(instr), .err(err), .cnt_ok(cntOk), .cnt_err(cntErr)
  );

  imm_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady4),
    .ExtOp(rExt), .imm(rImm), .opcode(rOp), .rd(rRd), .rs1(rRs1), .rs2(rRs2),
    .funct3(rF3), .funct7(rF7), .out_valid(outValid4), .out_ready(outReady),
    .instr(instr4), .err(err4), .cnt_ok(cntOk4), .cnt_err(cntErr4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAsserts++;
    assert (got === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkTrue(input string tag, input bit cond);
    nAsserts++;
    assert (cond) else begin
      nFails++;
      $error("FAIL %s: observed false expected true", tag);
    end
  endtask

  function automatic logic [31:0] bitAt(input logic [31:0] v, input int n);
    return (v >> n) & 32'd1;
  endfunction

  // Reference model: legality from signed ranges, packing by shift-and-mask.
  function automatic exp_t model(input logic [2:0] e, input logic [31:0] v,
                                 input logic [6:0] op, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [2:0] f3, input logic [6:0] f7);
    exp_t r;
    int   s;
    logic [31:0] com;
    s = $signed(v);
    com = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    r.ext = e;
    r.imm = v;
    r.err = 2'd0;
    case (e)
      3'd0, 3'd2: if (s < -2048 || s > 2047) r.err = 2'd1;
      3'd1:       if (v % 4096 != 0) r.err = 2'd1;
      3'd3: if (s < -4096 || s > 4095) r.err = 2'd1; else if (v % 2 != 0) r.err = 2'd2;
      3'd4: if (s < -1048576 || s > 1048575) r.err = 2'd1; else if (v % 2 != 0) r.err = 2'd2;
      3'd5: r.err = 2'd0;
      default: r.err = 2'd3;
    endcase
    case (e)
      3'd0: r.instr = ((v & 32'hFFF) << 20) | com | (32'(d) << 7);
      3'd1: r.instr = (v & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
      3'd2: r.instr = (((v >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | com | ((v & 32'h1F) << 7);
      3'd3: r.instr = (bitAt(v, 12) << 31) | (((v >> 5) & 32'h3F) << 25) | (32'(s2) << 20) |
                      com | (((v >> 1) & 32'hF) << 8) | (bitAt(v, 11) << 7);
      3'd4: r.instr = (bitAt(v, 20) << 31) | (((v >> 1) & 32'h3FF) << 21) | (bitAt(v, 11) << 20) |
                      (((v >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
      3'd5: r.instr = (32'(f7) << 25) | (32'(s2) << 20) | com | (32'(d) << 7);
      default: r.instr = 32'd0;
    endcase
    return r;
  endfunction

  // Decode-side immediate generator, used to confirm the round trip.
  function automatic logic [31:0] decodeImm(input logic [2:0] e, input logic [31:0] w);
    case (e)
      3'd0: return {{20{w[31]}}, w[31:20]};
      3'd1: return {w[31:12], 12'b0};
      3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic randReq(input bit legal);
    int n;
    rOp  = 7'($urandom);
    rRd  = 5'($urandom);
    rRs1 = 5'($urandom);
    rRs2 = 5'($urandom);
    rF3  = 3'($urandom);
    rF7  = 7'($urandom);
    if (!legal) begin
      rExt = 3'($urandom_range(0, 7));
      rImm = $urandom;
    end else begin
      rExt = 3'($urandom_range(0, 5));
      case (rExt)
        3'd0, 3'd2: begin n = $urandom_range(0, 4095); rImm = 32'(n - 2048); end
        3'd1:       rImm = $urandom & 32'hFFFFF000;
        3'd3:       begin n = $urandom_range(0, 4095); rImm = 32'(2 * n - 4096); end
        3'd4:       begin n = $urandom_range(0, 1048575); rImm = 32'(2 * n - 1048576); end
        default:    rImm = $urandom;
      endcase
    end
  endtask

  // One clock: score any output transfer, log any input transfer, advance.
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    if (outValid && outReady) begin
      checkTrue("spuriousWord", q.size() > 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("instr", instr, e.instr);
        check("err", 32'(err), 32'(e.err));
        if (e.err == 2'd0 && e.ext <= 3'd4)
          check("roundTrip", decodeImm(e.ext, instr), e.imm);
        if (e.err == 2'd0) okCount++; else errCount++;
        delivered++;
      end
    end
    acc = inValid && inReady;
    if (acc) q.push_back(model(rExt, rImm, rOp, rRd, rRs1, rRs2, rF3, rF7));
    if (!inReady) sawStall = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic sendOne(input string tag, input logic [31:0] expInstr, input logic [1:0] expErr);
    inValid  = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    checkTrue({tag, ".inReady"}, inReady);
    @(posedge clk); #1;
    inValid = 1'b0;
    @(negedge clk);
    check({tag, ".lat1"}, 32'(outValid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".valid"}, 32'(outValid), 32'd1);
    check({tag, ".instr"}, instr, expInstr);
    check({tag, ".err"}, 32'(err), 32'(expErr));
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    inValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    int sent;
    int cyc;
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
    rExt = 3'd0; rImm = 32'd0; rOp = 7'd0; rRd = 5'd0; rRs1 = 5'd0; rRs2 = 5'd0;
    rF3 = 3'd0; rF7 = 7'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst.outValid", 32'(outValid), 32'd0);
    check("rst.inReady", 32'(inReady), 32'd1);
    check("rst.instr", instr, 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.cntOk", 32'(cntOk), 32'd0);
    check("rst.cntErr", 32'(cntErr), 32'd0);

    rExt = 3'd0; rImm = 32'hFFFFF800; rRs1 = 5'd2; rRd = 5'd1; rF3 = 3'd0; rOp = 7'h13;
    sendOne("iType", 32'h80010093, 2'b00);
    rExt = 3'd3; rImm = 32'hFFFFFFFC; rRs1 = 5'd1; rRs2 = 5'd0; rF3 = 3'd1; rOp = 7'h63;
    sendOne("bType", 32'hFE009EE3, 2'b00);
    rImm = 32'h00001001;
    sendOne("bRange", model(rExt, rImm, rOp, rRd, rRs1, rRs2, rF3, rF7).instr, 2'b01);
    rImm = 32'd3;
    sendOne("bAlign", model(rExt, rImm, rOp, rRd, rRs1, rRs2, rF3, rF7).instr, 2'b10);
    rExt = 3'd4; rImm = 32'h000FFFFE; rRd = 5'd1; rOp = 7'h6F;
    sendOne("jType", 32'h7FFFF0EF, 2'b00);
    rImm = 32'h00100000;
    sendOne("jRange", model(rExt, rImm, rOp, rRd, rRs1, rRs2, rF3, rF7).instr, 2'b01);
    rExt = 3'd1; rImm = 32'h12345001; rRd = 5'd5; rOp = 7'h37;
    sendOne("uRange", 32'h123452B7, 2'b01);
    rExt = 3'd7; rImm = 32'h0000_0010;
    sendOne("illegal", 32'd0, 2'b11);
    check("dir.cntOk", 32'(cntOk), 32'd3);
    check("dir.cntErr", 32'(cntErr), 32'd5);

    // Fill both stages under backpressure, then reset mid-flight.
    outReady = 1'b0;
    rExt = 3'd0; rImm = 32'd5;
    inValid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(negedge clk);
    check("full.outValid", 32'(outValid), 32'd1);
    check("full.inReady", 32'(inReady), 32'd0);
    @(posedge clk); #1;
    doReset();
    check("midRst.outValid", 32'(outValid), 32'd0);
    check("midRst.cntOk", 32'(cntOk), 32'd0);
    check("midRst.cntErr", 32'(cntErr), 32'd0);
    check("midRst.inReady", 32'(inReady), 32'd1);
    outReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midRst.noStale", 32'(outValid), 32'd0);
      @(posedge clk); #1;
    end

    // Eight back-to-back requests with out_ready low on cycles 3..6.
    q.delete(); okCount = 0; errCount = 0; delivered = 0; sawStall = 1'b0;
    sent = 0; cyc = 0;
    randReq(1'b1);
    while ((sent < 8 || q.size() > 0) && cyc < 60) begin
      inValid  = (sent < 8);
      outReady = !(cyc >= 3 && cyc <= 6);
      step(acc);
      if (acc) begin sent++; randReq(1'b1); end
      cyc++;
    end
    inValid = 1'b0;
    check("bp.leftover", 32'(q.size()), 32'd0);
    check("bp.delivered", 32'(delivered), 32'd8);
    checkTrue("bp.inReadyDropped", sawStall);
    check("bp.cntOk", 32'(cntOk), 32'(okCount));
    check("bp.cntOk8", 32'(okCount), 32'd8);

    // Randomized stream: mostly legal requests, some arbitrary ones.
    doReset();
    q.delete(); okCount = 0; errCount = 0; delivered = 0;
    sent = 0; cyc = 0;
    randReq($urandom_range(0, 9) != 0);
    while ((sent < 10000 || q.size() > 0) && cyc < 40000) begin
      inValid  = (sent < 10000) && ($urandom_range(0, 7) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) begin sent++; randReq($urandom_range(0, 9) != 0); end
      cyc++;
    end
    inValid = 1'b0;
    check("rnd.leftover", 32'(q.size()), 32'd0);
    check("rnd.delivered", 32'(delivered), 32'd10000);
    check("rnd.cntOk", 32'(cntOk), 32'((okCount > 65535) ? 65535 : okCount));
    check("rnd.cntErr", 32'(cntErr), 32'((errCount > 65535) ? 65535 : errCount));
    check("rnd.cntOkSat4", 32'(cntOk4), 32'((okCount > 15) ? 15 : okCount));
    check("rnd.cntErrSat4", 32'(cntErr4), 32'((errCount > 15) ? 15 : errCount));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-side immediate generator: takes a 32-bit immediate, register/opcode fields and an ExtOp format code, and packs them into a 32-bit RV32I instruction word.
- Checks immediate range and alignment per format, and flags immediates that cannot be represented.
- Sits in the test and assembler path: it feeds instruction memory loaders and round-trip checks against the core's immediate decoder.
- Two-stage pipeline with valid/ready handshakes on both sides, plus saturating statistics counters.

Parameters:
- CNT_W, 16, width of the accepted and error statistics counters.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- ExtOp  input  3  format: 000 I, 001 U, 010 S, 011 B, 100 J, 101 R (no immediate), 110/111 illegal
- imm  input  32  immediate value, full sign-extended or byte-offset form
- opcode  input  7  instr[6:0]
- rd  input  5  destination register
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- funct3  input  3  function field 3
- funct7  input  7  function field 7
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts
- instr  output  32  encoded instruction
- err  output  2  error code: 00 ok, 01 range, 10 misaligned, 11 illegal ExtOp
- cnt_ok  output  CNT_W  count of words delivered with err = 00
- cnt_err  output  CNT_W  count of words delivered with err != 00

Behaviour:
- Reset (rst = 1 at a clock edge):
  - out_valid, the internal stage-1 valid, instr, err, cnt_ok and cnt_err all go to 0.
  - A request in flight is discarded.
  - in_ready reads 1 in the cycle after reset.
- Handshake:
  - Transfer occurs when valid and ready are both high at a clock edge.
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, which is combinational from out_ready.
  - out_valid and its payload stay stable until out_ready is high.
- Latency and throughput:
  - 2 cycles from input acceptance to out_valid.
  - Sustained throughput is 1 word per cycle.
  - A stall freezes both stages without losing data; no bubble is inserted when the stall releases.
- Stage 1: registers all fields and computes err:
  - I, S: range error unless imm[31:11] is all equal (12-bit signed).
  - B: range error unless imm[31:12] is all equal; misaligned if imm[0] = 1.
  - J: range error unless imm[31:20] is all equal; misaligned if imm[0] = 1.
  - U: range error unless imm[11:0] = 0.
  - R: immediate ignored, never errors.
  - 110/111: err = 11.
  - Priority: illegal > range > misaligned.
- Stage 2: packs the word from the truncated immediate, even when err != 0 (no masking):
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - U: {imm[31:12], rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - Illegal ExtOp: instr = 0.
- Counters:
  - Increment on an output transfer, cnt_ok when err = 00, cnt_err otherwise.
  - Each saturates at all-ones and does not wrap.
  - Cleared only by rst.
- Round-trip invariant: for every delivered word with err = 00 and ExtOp ≤ 100, decoding instr with the same ExtOp yields imm exactly.

Decomposition:
- Shared package holds:
  - ExtOp encodings (EXT_I … EXT_R), identical to the decoder's 000..100 values.
  - Error codes ERR_OK, ERR_RANGE, ERR_ALIGN, ERR_OP.
- One natural sub-module: imm_range_check, combinational (ExtOp, imm) -> err, instantiated in stage 1 and reusable by the assembler tooling bench.

Test Plan:
- I-type: ExtOp = 000, imm = 0xFFFFF800, rs1 = 2, rd = 1, funct3 = 0, opcode = 0x13 -> instr = 0x80010093, err = 00, out_valid 2 cycles after acceptance.
- B-type: ExtOp = 011, imm = 0xFFFFFFFC, rs1 = 1, rs2 = 0, funct3 = 1, opcode = 0x63 -> instr = 0xFE009EE3, err = 00; same request with imm = 0x1001 -> err = 01; with imm = 3 -> err = 10.
- J and U edge cases:
  - J-type with imm = 0x000FFFFE, rd = 1, opcode = 0x6F -> instr = 0x7FFFF0EF, err = 00.
  - J-type with imm = 0x00100000 -> err = 01.
  - U-type with imm = 0x12345001 -> err = 01.
- Backpressure: stream 8 back-to-back requests while holding out_ready low for cycles 3–6 -> in_ready drops once both stages are full, no word is lost or duplicated, order is preserved, and cnt_ok = 8 at the end.
- Reset and illegal ExtOp:
  - Assert rst while both stages are valid -> out_valid = 0 and counters = 0 in the next cycle, with no stale word emitted.
  - ExtOp = 111 -> instr = 0, err = 11, cnt_err incremented.
- Random round-trip: 10k random legal requests checked through the decoder -> imm recovered exactly; cnt_ok saturation forced with CNT_W = 4 holds at 15.
